// File: rtl/gps_pkg.sv
// gps_pkg: shared definitions for the GPS round scheduler slice.
//   - scheduler state encoding
//   - captured code widths (C/A 13, P 128, L 128)
//   - default round timeout in clock cycles
package gps_pkg;

  localparam int unsigned CA_W            = 13;
  localparam int unsigned P_W             = 128;
  localparam int unsigned L_W             = 128;
  localparam int unsigned TIMEOUT_DEFAULT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CLR,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/gps_round_scheduler_if.sv
// gps_round_scheduler_if: requester-side bus of the GPS round scheduler.
//   req_i     per-requester round request (level, held until ack)
//   req_sv_i  per-requester satellite number, requester k at [k*SV_W +: SV_W]
//   ack_o     one-cycle ack pulse to the granted requester
//   err_o     valid with ack_o, 1 = round timed out
//   gnt_id_o  requester owning the current or last round
//   *_code_o  captured codes, stable from ack until the next capture
//   busy_o    scheduler not idle
// Modports: slave = scheduler side, master = requester side.
interface gps_round_scheduler_if #(
  parameter int unsigned SV_W = 6
);

  logic [1:0]              req_i;
  logic [2*SV_W-1:0]       req_sv_i;
  logic [1:0]              ack_o;
  logic                    err_o;
  logic                    gnt_id_o;
  logic [gps_pkg::CA_W-1:0] ca_code_o;
  logic [gps_pkg::P_W-1:0]  p_code_o;
  logic [gps_pkg::L_W-1:0]  l_code_o;
  logic                    busy_o;

  modport slave (
    input  req_i, req_sv_i,
    output ack_o, err_o, gnt_id_o, ca_code_o, p_code_o, l_code_o, busy_o
  );

  modport master (
    output req_i, req_sv_i,
    input  ack_o, err_o, gnt_id_o, ca_code_o, p_code_o, l_code_o, busy_o
  );

endinterface

// File: rtl/gps_rr_arb.sv
// gps_rr_arb: two-requester round-robin grant.
//   req       request vector
//   last_gnt  requester granted last; the other one wins a tie
//   gnt_valid at least one request present
//   gnt_id    granted requester
module gps_rr_arb (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (req == 2'b11) gnt_id = ~last_gnt;
    else              gnt_id = req[1];
  end

endmodule

// File: rtl/gps_round_scheduler.sv
// gps_round_scheduler: arbitrates two requesters for rounds on a GPS code
// core. A round pulses startRound until the stale valid clears, waits for a
// fresh valid, captures the C/A, P and L codes and acks the owner. A
// saturating counter bounds each round; expiry acks with err_o=1 and leaves
// the captured codes untouched.
//   wb_clk_i, wb_rst_ni  clock, synchronous active-low reset
//   bus                  requester bus (slave modport)
//   gps_start_o, gps_sv_o   drive the GPS core's startRound / sv_num
//   gps_ca_i, gps_p_i, gps_l_i, gps_valid_i  GPS core results (synchronised)
module gps_round_scheduler
  import gps_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned SV_W           = 6
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  gps_round_scheduler_if.slave  bus,
  output logic                  gps_start_o,
  output logic [SV_W-1:0]       gps_sv_o,
  input  logic [CA_W-1:0]       gps_ca_i,
  input  logic [P_W-1:0]        gps_p_i,
  input  logic [L_W-1:0]        gps_l_i,
  input  logic                  gps_valid_i
);

  localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_gnt;
  logic             arb_valid;
  logic             arb_id;
  logic [SV_W-1:0]  arb_sv;
  logic             timeout;

  gps_rr_arb u_arb (
    .req       (bus.req_i),
    .last_gnt  (last_gnt),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  assign arb_sv  = arb_id ? bus.req_sv_i[2*SV_W-1:SV_W] : bus.req_sv_i[SV_W-1:0];
  assign timeout = (cnt == CNT_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      last_gnt      <= 1'b1;   // requester 0 wins the first tie
      gps_start_o   <= 1'b0;
      gps_sv_o      <= '0;
      bus.ack_o     <= '0;
      bus.err_o     <= 1'b0;
      bus.gnt_id_o  <= 1'b0;
      bus.busy_o    <= 1'b0;
      bus.ca_code_o <= '0;
      bus.p_code_o  <= '0;
      bus.l_code_o  <= '0;
    end else begin
      bus.ack_o <= '0;
      bus.err_o <= 1'b0;
      // Timeout is only reached in START/CLR/WAIT and always leaves them, so
      // stopping the count at CNT_LAST is the saturation point.
      if ((state == ST_START || state == ST_CLR || state == ST_WAIT) && !timeout)
        cnt <= cnt + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            bus.gnt_id_o <= arb_id;
            last_gnt     <= arb_id;
            gps_sv_o     <= arb_sv;
            cnt          <= '0;
            gps_start_o  <= 1'b1;
            bus.busy_o   <= 1'b1;
            state        <= ST_START;
          end
        end
        ST_START, ST_CLR: begin
          if (timeout) begin
            gps_start_o <= 1'b0;
            bus.ack_o   <= bus.gnt_id_o ? 2'b10 : 2'b01;
            bus.err_o   <= 1'b1;
            state       <= ST_DONE;
          end else if (state == ST_CLR) begin
            state <= ST_WAIT;
          end else if (!gps_valid_i) begin
            gps_start_o <= 1'b0;
            state       <= ST_CLR;
          end
        end
        ST_WAIT: begin
          // A fresh valid beats a coincident timeout.
          if (gps_valid_i) begin
            bus.ca_code_o <= gps_ca_i;
            bus.p_code_o  <= gps_p_i;
            bus.l_code_o  <= gps_l_i;
            bus.ack_o     <= bus.gnt_id_o ? 2'b10 : 2'b01;
            state         <= ST_DONE;
          end else if (timeout) begin
            bus.ack_o <= bus.gnt_id_o ? 2'b10 : 2'b01;
            bus.err_o <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          bus.busy_o <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_round_scheduler.sv
// tb_gps_round_scheduler: directed self-checking bench for gps_round_scheduler
// with TIMEOUT_CYCLES=16, SV_W=6.
module tb_gps_round_scheduler;
  import gps_pkg::*;

  localparam int unsigned SV_W = 6;

  logic             clk;
  logic             rst_n;
  logic             gps_start;
  logic [SV_W-1:0]  gps_sv;
  logic [CA_W-1:0]  gps_ca;
  logic [P_W-1:0]   gps_p;
  logic [L_W-1:0]   gps_l;
  logic             gps_valid;

  int unsigned n_assert;
  int unsigned n_fail;

  gps_round_scheduler_if #(.SV_W(SV_W)) bus ();

  gps_round_scheduler #(
    .TIMEOUT_CYCLES (16),
    .SV_W           (SV_W)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .bus         (bus),
    .gps_start_o (gps_start),
    .gps_sv_o    (gps_sv),
    .gps_ca_i    (gps_ca),
    .gps_p_i     (gps_p),
    .gps_l_i     (gps_l),
    .gps_valid_i (gps_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] L_A5 = {16{8'hA5}};
  localparam logic [127:0] L_3C = {16{8'h3C}};
  localparam logic [127:0] P_DB = {4{32'hDEADBEEF}};

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.req_i    = 2'b00;
    bus.req_sv_i = '0;
    gps_valid = 1'b0;
    gps_ca    = '0;
    gps_p     = '0;
    gps_l     = '0;
    tick();
    tick();

    // Reset state
    check("rst_ack",   128'(bus.ack_o), 128'd0);
    check("rst_err",   128'(bus.err_o), 128'd0);
    check("rst_busy",  128'(bus.busy_o), 128'd0);
    check("rst_gnt",   128'(bus.gnt_id_o), 128'd0);
    check("rst_start", 128'(gps_start), 128'd0);
    check("rst_sv",    128'(gps_sv), 128'd0);
    check("rst_l",     bus.l_code_o, 128'd0);

    // Round for requester 0, sv=12, valid arrives late in WAIT
    rst_n = 1'b1;
    bus.req_sv_i = {6'd33, 6'd12};
    bus.req_i    = 2'b01;
    tick();
    check("r0_gnt",   128'(bus.gnt_id_o), 128'd0);
    check("r0_start", 128'(gps_start), 128'd1);
    check("r0_busy",  128'(bus.busy_o), 128'd1);
    check("r0_sv",    128'(gps_sv), 128'd12);
    tick();
    check("r0_clr_start", 128'(gps_start), 128'd0);
    tick();
    tick();
    check("r0_wait_ack", 128'(bus.ack_o), 128'd0);
    gps_valid = 1'b1;
    gps_l     = L_A5;
    gps_ca    = 13'h1A5A;
    gps_p     = P_DB;
    tick();
    check("r0_ack",  128'(bus.ack_o), 128'b01);
    check("r0_err",  128'(bus.err_o), 128'd0);
    check("r0_l",    bus.l_code_o, L_A5);
    check("r0_ca",   128'(bus.ca_code_o), 128'h1A5A);
    check("r0_p",    bus.p_code_o, P_DB);
    check("r0_sv_done", 128'(gps_sv), 128'd12);
    bus.req_i = 2'b00;
    gps_valid = 1'b0;
    tick();
    check("r0_ack_once", 128'(bus.ack_o), 128'd0);
    check("r0_idle",     128'(bus.busy_o), 128'd0);

    // Minimum latency: request-to-ack in four edges, requester 1, sv=33
    bus.req_i = 2'b10;
    tick();
    check("lat_gnt", 128'(bus.gnt_id_o), 128'd1);
    check("lat_sv",  128'(gps_sv), 128'd33);
    tick();
    tick();
    check("lat_noack", 128'(bus.ack_o), 128'd0);
    gps_valid = 1'b1;
    gps_ca    = 13'h0123;
    tick();
    check("lat_ack", 128'(bus.ack_o), 128'b10);
    check("lat_ca",  128'(bus.ca_code_o), 128'h0123);
    check("lat_l",   bus.l_code_o, L_A5);
    gps_valid = 1'b0;
    bus.req_i = 2'b00;
    tick();

    // Both requesting continuously: grants alternate 0,1,0,1
    bus.req_i = 2'b11;
    for (int r = 0; r < 4; r++) begin
      tick();
      check("alt_gnt", 128'(bus.gnt_id_o), 128'(r % 2));
      tick();
      tick();
      gps_valid = 1'b1;
      gps_l     = 128'h77 + 128'(r);
      tick();
      check("alt_ack", 128'(bus.ack_o), (r % 2 == 1) ? 128'b10 : 128'b01);
      gps_valid = 1'b0;
      tick();
      check("alt_nogrant_in_done", 128'(bus.busy_o), 128'd0);
    end
    bus.req_i = 2'b00;

    // Valid stuck high in START: timeout 16 edges after the grant
    bus.req_i = 2'b01;
    gps_valid = 1'b1;
    gps_l     = '1;
    gps_ca    = '1;
    tick();
    repeat (15) tick();
    check("stk_noack", 128'(bus.ack_o), 128'd0);
    check("stk_start", 128'(gps_start), 128'd1);
    tick();
    check("stk_ack", 128'(bus.ack_o), 128'b01);
    check("stk_err", 128'(bus.err_o), 128'd1);
    check("stk_l",   bus.l_code_o, 128'h7A);
    check("stk_ca",  128'(bus.ca_code_o), 128'h0123);
    check("stk_start_off", 128'(gps_start), 128'd0);
    bus.req_i = 2'b00;
    gps_valid = 1'b0;
    tick();
    check("stk_idle", 128'(bus.busy_o), 128'd0);

    // Valid never rises: timeout from WAIT
    bus.req_i = 2'b10;
    tick();
    repeat (15) tick();
    check("nv_noack", 128'(bus.ack_o), 128'd0);
    check("nv_busy",  128'(bus.busy_o), 128'd1);
    tick();
    check("nv_ack", 128'(bus.ack_o), 128'b10);
    check("nv_err", 128'(bus.err_o), 128'd1);
    bus.req_i = 2'b00;
    tick();

    // Valid on the timeout cycle: capture wins
    bus.req_i = 2'b01;
    gps_l     = L_3C;
    tick();
    repeat (15) tick();
    check("tie_noack", 128'(bus.ack_o), 128'd0);
    gps_valid = 1'b1;
    tick();
    check("tie_ack", 128'(bus.ack_o), 128'b01);
    check("tie_err", 128'(bus.err_o), 128'd0);
    check("tie_l",   bus.l_code_o, L_3C);
    gps_valid = 1'b0;
    bus.req_i = 2'b00;
    tick();

    // Reset during WAIT
    bus.req_i = 2'b01;
    tick();
    tick();
    tick();
    check("mr_busy", 128'(bus.busy_o), 128'd1);
    rst_n     = 1'b0;
    bus.req_i = 2'b00;
    tick();
    check("mr_start", 128'(gps_start), 128'd0);
    check("mr_busy0", 128'(bus.busy_o), 128'd0);
    check("mr_ack",   128'(bus.ack_o), 128'd0);
    check("mr_l",     bus.l_code_o, 128'd0);
    check("mr_ca",    128'(bus.ca_code_o), 128'd0);
    check("mr_sv",    128'(gps_sv), 128'd0);
    check("mr_gnt",   128'(bus.gnt_id_o), 128'd0);
    rst_n = 1'b1;
    tick();
    check("mr_noack1", 128'(bus.ack_o), 128'd0);
    tick();
    check("mr_noack2", 128'(bus.ack_o), 128'd0);

    // After reset a tie goes to requester 0, then requester 1 drops mid-round
    bus.req_i = 2'b11;
    tick();
    check("pr_gnt0", 128'(bus.gnt_id_o), 128'd0);
    tick();
    tick();
    gps_valid = 1'b1;
    tick();
    check("pr_ack0", 128'(bus.ack_o), 128'b01);
    gps_valid = 1'b0;
    tick();
    tick();
    check("dr_gnt1", 128'(bus.gnt_id_o), 128'd1);
    check("dr_sv",   128'(gps_sv), 128'd33);
    tick();
    tick();
    bus.req_i = 2'b00;
    tick();
    check("dr_busy", 128'(bus.busy_o), 128'd1);
    check("dr_sv_hold", 128'(gps_sv), 128'd33);
    gps_valid = 1'b1;
    tick();
    check("dr_ack", 128'(bus.ack_o), 128'b10);
    check("dr_err", 128'(bus.err_o), 128'd0);
    gps_valid = 1'b0;
    tick();
    check("dr_ack_once", 128'(bus.ack_o), 128'd0);
    check("dr_idle",     128'(bus.busy_o), 128'd0);
    tick();
    check("dr_no_regrant", 128'(bus.busy_o), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
